// File: rtl/ex_div_sequencer_pkg.sv
// Shared types and widths for the EX-stage divide sequencer.
package ex_div_sequencer_pkg;

    localparam int DIV_XLEN = 64;
    localparam int DIV_WLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/ex_div_sequencer_div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, subtract divisor if it fits.
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] div,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [2*XLEN:0] pair_shifted;
    logic [XLEN:0]   rem_shifted;

    // The remainder stays below the divisor, so its top bit is always shifted out as zero.
    assign pair_shifted = {rem, quo} << 1;
    assign rem_shifted  = pair_shifted[2*XLEN:XLEN];

    always_comb begin
        rem_next = rem_shifted;
        quo_next = pair_shifted[XLEN-1:0];
        if (rem_shifted >= {1'b0, div}) begin
            rem_next    = rem_shifted - {1'b0, div};
            quo_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/ex_div_sequencer.sv
// Multi-cycle RV64M divide/remainder sequencer; stalls EX via o_ex_ready while it iterates.
module ex_div_sequencer
    import ex_div_sequencer_pkg::*;
#(
    parameter int XLEN = DIV_XLEN,
    parameter int WLEN = DIV_WLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  div_op_t         i_op,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd,
    input  logic            i_flush,
    output logic            o_ex_ready,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd
);

    div_state_t      state_reg, state_next;
    div_op_t         op_reg, op_next;
    logic            word_reg, word_next;
    logic [4:0]      rd_reg, rd_next;
    logic [XLEN-1:0] dvd_reg, dvd_next;
    logic [XLEN-1:0] dvs_reg, dvs_next;
    logic [XLEN:0]   rem_reg, rem_next;
    logic [XLEN-1:0] quo_reg, quo_next;
    logic [6:0]      cnt_reg, cnt_next;
    logic            qneg_reg, qneg_next;
    logic            rneg_reg, rneg_next;
    logic [XLEN-1:0] result_reg, result_next;

    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;
    logic            is_signed, is_quot, s1, s2;
    logic [XLEN-1:0] dvd_abs, dvs_abs, min_n, ones_n, q_fix, r_fix;

    // Keep only the low WLEN bits for word ops.
    function automatic logic [XLEN-1:0] mask_n(input logic [XLEN-1:0] v, input logic word);
        return word ? {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]} : v;
    endfunction

    // Word results are always sign-extended from bit WLEN-1.
    function automatic logic [XLEN-1:0] fit_n(input logic [XLEN-1:0] v, input logic word);
        return word ? {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]} : v;
    endfunction

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .div      (dvs_reg),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        word_next   = word_reg;
        rd_next     = rd_reg;
        dvd_next    = dvd_reg;
        dvs_next    = dvs_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        cnt_next    = cnt_reg;
        qneg_next   = qneg_reg;
        rneg_next   = rneg_reg;
        result_next = result_reg;

        is_signed = (op_reg == DIV_OP_DIV) || (op_reg == DIV_OP_REM);
        is_quot   = (op_reg == DIV_OP_DIV) || (op_reg == DIV_OP_DIVU);
        s1        = is_signed && (word_reg ? dvd_reg[WLEN-1] : dvd_reg[XLEN-1]);
        s2        = is_signed && (word_reg ? dvs_reg[WLEN-1] : dvs_reg[XLEN-1]);
        dvd_abs   = mask_n(s1 ? -dvd_reg : dvd_reg, word_reg);
        dvs_abs   = mask_n(s2 ? -dvs_reg : dvs_reg, word_reg);
        min_n     = word_reg ? (XLEN'(1) << (WLEN-1)) : (XLEN'(1) << (XLEN-1));
        ones_n    = mask_n({XLEN{1'b1}}, word_reg);
        q_fix     = qneg_reg ? -quo_reg : quo_reg;
        r_fix     = rneg_reg ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (i_start) begin
                    state_next = ST_PREP;
                    op_next    = i_op;
                    word_next  = i_word;
                    rd_next    = i_rd;
                    dvd_next   = mask_n(i_rs1, i_word);
                    dvs_next   = mask_n(i_rs2, i_word);
                end
            end
            ST_PREP: begin
                if (dvs_reg == '0) begin
                    result_next = fit_n(is_quot ? {XLEN{1'b1}} : dvd_reg, word_reg);
                    state_next  = ST_DONE;
                end else if (is_signed && dvd_reg == min_n && dvs_reg == ones_n) begin
                    result_next = fit_n(is_quot ? dvd_reg : '0, word_reg);
                    state_next  = ST_DONE;
                end else begin
                    // Word dividends sit in the upper half so the same 64-bit shifter feeds bit 31 first.
                    quo_next   = word_reg ? (dvd_abs << WLEN) : dvd_abs;
                    dvs_next   = dvs_abs;
                    rem_next   = '0;
                    qneg_next  = s1 ^ s2;
                    rneg_next  = s1;
                    cnt_next   = word_reg ? 7'(WLEN) : 7'(XLEN);
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_next = step_rem;
                quo_next = step_quo;
                cnt_next = cnt_reg - 7'd1;
                if (cnt_reg == 7'd1) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                result_next = fit_n(is_quot ? q_fix : r_fix, word_reg);
                state_next  = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase

        // A flush kills the op in flight and also suppresses a same-cycle start.
        if (i_flush) begin
            state_next  = ST_IDLE;
            result_next = result_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            op_reg     <= DIV_OP_DIV;
            word_reg   <= 1'b0;
            rd_reg     <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            cnt_reg    <= '0;
            qneg_reg   <= 1'b0;
            rneg_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            word_reg   <= word_next;
            rd_reg     <= rd_next;
            dvd_reg    <= dvd_next;
            dvs_reg    <= dvs_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            cnt_reg    <= cnt_next;
            qneg_reg   <= qneg_next;
            rneg_reg   <= rneg_next;
            result_reg <= result_next;
        end
    end

    assign o_ex_ready = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign o_busy     = (state_reg == ST_PREP) || (state_reg == ST_CALC) || (state_reg == ST_FIX);
    assign o_done     = (state_reg == ST_DONE);
    assign o_result   = result_reg;
    assign o_rd       = rd_reg;

    // EX is frozen while busy, so a start here means the pipeline broke its handshake.
    a_no_start_busy: assert property (@(posedge clk) disable iff (rst) !(i_start && o_busy));

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Directed-vector bench for ex_div_sequencer: results, latency, stall, flush, reset, back-to-back.
module tb_ex_div_sequencer;
    import ex_div_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    div_op_t     i_op;
    logic        i_word;
    logic [63:0] i_rs1;
    logic [63:0] i_rs2;
    logic [4:0]  i_rd;
    logic        i_flush;
    logic        o_ex_ready;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_result;
    logic [4:0]  o_rd;

    int checks = 0;
    int errors = 0;

    localparam int LAT64 = 66;
    localparam int LAT32 = 34;
    localparam int LATSP = 1;

    ex_div_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_word     (i_word),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .i_rd       (i_rd),
        .i_flush    (i_flush),
        .o_ex_ready (o_ex_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_rd       (o_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one op (back-to-back if called while o_done is high) and waits for its result.
    task automatic run_op(input string tag, input div_op_t op, input logic word,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        int ready_hi;
        if (!o_done) @(negedge clk);
        check({tag, "_ready_in"}, 64'(o_ex_ready), 64'd1);
        i_start = 1'b1;
        i_op    = op;
        i_word  = word;
        i_rs1   = a;
        i_rs2   = b;
        i_rd    = rd;
        @(posedge clk);
        #1;
        i_start  = 1'b0;
        lat      = 0;
        ready_hi = 0;
        while (!o_done && lat < 200) begin
            if (o_ex_ready) ready_hi++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, o_result, exp);
        check({tag, "_rd"}, 64'(o_rd), 64'(rd));
        check({tag, "_stall"}, 64'(ready_hi), 64'd0);
        $display("op %s: result=%h rd=%0d latency=%0d", tag, o_result, o_rd, lat);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // Counts o_done pulses over a window; used after aborts.
    task automatic watch_no_done(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (o_done) seen++;
        end
        check({tag, "_no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        i_op    = DIV_OP_DIV;
        i_word  = 1'b0;
        i_rs1   = '0;
        i_rs2   = '0;
        i_rd    = '0;
        i_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(o_ex_ready), 64'd1);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_result", o_result, 64'd0);
        check("rst_rd", 64'(o_rd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // 64-bit unsigned and signed
        run_op("divu_100_7", DIV_OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd3, 64'd14, LAT64);
        idle(2);
        check("done_pulse", 64'(o_done), 64'd0);
        run_op("remu_100_7", DIV_OP_REMU, 1'b0, 64'd100, 64'd7, 5'd4, 64'd2, LAT64);
        idle(1);
        run_op("div_m7_2", DIV_OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5,
               64'hFFFF_FFFF_FFFF_FFFD, LAT64);
        idle(1);
        run_op("rem_m7_2", DIV_OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6,
               64'hFFFF_FFFF_FFFF_FFFF, LAT64);
        idle(1);
        run_op("div_100_m7", DIV_OP_DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd7,
               64'hFFFF_FFFF_FFFF_FFF2, LAT64);
        idle(1);
        run_op("divu_max_3", DIV_OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd8,
               64'h5555_5555_5555_5555, LAT64);
        idle(1);

        // Special cases: divide by zero and signed overflow
        run_op("div_x_0", DIV_OP_DIV, 1'b0, 64'd5, 64'd0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, LATSP);
        idle(1);
        run_op("remu_x_0", DIV_OP_REMU, 1'b0, 64'h1234, 64'd0, 5'd10, 64'h1234, LATSP);
        idle(1);
        run_op("div_ovf", DIV_OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
               64'h8000_0000_0000_0000, LATSP);
        idle(1);
        run_op("rem_ovf", DIV_OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
               64'd0, LATSP);
        idle(1);

        // Word forms
        run_op("divw", DIV_OP_DIV, 1'b1, 64'h1_0000_0010, 64'h4, 5'd13, 64'd4, LAT32);
        idle(1);
        run_op("divuw_sext", DIV_OP_DIVU, 1'b1, 64'hFFFF_FFFF, 64'd1, 5'd14,
               64'hFFFF_FFFF_FFFF_FFFF, LAT32);
        idle(1);
        run_op("remw_m7_2", DIV_OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd15,
               64'hFFFF_FFFF_FFFF_FFFF, LAT32);
        idle(1);
        run_op("divuw_hi", DIV_OP_DIVU, 1'b1, 64'h8000_0000, 64'd1, 5'd16,
               64'hFFFF_FFFF_8000_0000, LAT32);
        idle(1);
        run_op("divw_ovf", DIV_OP_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd17,
               64'hFFFF_FFFF_8000_0000, LATSP);
        idle(1);

        // Flush mid-operation
        @(negedge clk);
        i_start = 1'b1; i_op = DIV_OP_DIVU; i_word = 1'b0;
        i_rs1 = 64'd1000; i_rs2 = 64'd3; i_rd = 5'd20;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        idle(19);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        check("flush_ready", 64'(o_ex_ready), 64'd1);
        check("flush_busy", 64'(o_busy), 64'd0);
        check("flush_done", 64'(o_done), 64'd0);
        watch_no_done("flush", 70);
        run_op("after_flush", DIV_OP_DIVU, 1'b0, 64'd1000, 64'd3, 5'd21, 64'd333, LAT64);
        idle(1);

        // Start together with flush is dropped
        @(negedge clk);
        i_start = 1'b1; i_flush = 1'b1; i_op = DIV_OP_DIV;
        @(posedge clk);
        #1;
        i_start = 1'b0; i_flush = 1'b0;
        check("start_flush_busy", 64'(o_busy), 64'd0);
        check("start_flush_ready", 64'(o_ex_ready), 64'd1);
        idle(1);

        // Back-to-back: second op issued during DONE of the first
        run_op("b2b_a", DIV_OP_DIVU, 1'b0, 64'd81, 64'd9, 5'd22, 64'd9, LAT64);
        run_op("b2b_b", DIV_OP_REMU, 1'b0, 64'd82, 64'd9, 5'd23, 64'd1, LAT64);
        idle(1);

        // Reset mid-operation
        @(negedge clk);
        i_start = 1'b1; i_op = DIV_OP_DIV; i_word = 1'b0;
        i_rs1 = 64'd500; i_rs2 = 64'd7; i_rd = 5'd24;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        idle(29);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", 64'(o_ex_ready), 64'd1);
        check("rst_mid_busy", 64'(o_busy), 64'd0);
        check("rst_mid_done", 64'(o_done), 64'd0);
        check("rst_mid_result", o_result, 64'd0);
        check("rst_mid_rd", 64'(o_rd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        watch_no_done("rst_mid", 70);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
